alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU: round-robin grant,
// operand latching, one-cycle execute and a held response until handshake.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,

    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,

    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_prio;
    logic               r_gnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [WIDTH-1:0]   r_resp_data;
    logic               r_resp_zero;
    logic [CNT_W-1:0]   r_op_count;

    logic               w_idle;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_accept;
    logic               w_resp_hs;

    // Grant decode; rst_n gating keeps both readies low while reset is held.
    always_comb begin
        w_idle    = 1'b0;
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_accept  = 1'b0;
        w_resp_hs = 1'b0;

        w_idle    = rst_n && (r_state == IDLE);
        w_gnt0    = w_idle && req0_valid && (!req1_valid || !r_prio);
        w_gnt1    = w_idle && req1_valid && (!req0_valid ||  r_prio);
        w_accept  = w_gnt0 || w_gnt1;
        w_resp_hs = (r_state == RESP) && (r_gnt ? resp1_ready : resp0_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (w_resp_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, result capture in EXEC, bookkeeping on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio      <= 1'b0;
            r_gnt       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_ctrl      <= '0;
            r_resp_data <= '0;
            r_resp_zero <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_accept) begin
                r_gnt  <= w_gnt1;
                r_a    <= w_gnt1 ? req1_a    : req0_a;
                r_b    <= w_gnt1 ? req1_b    : req0_b;
                r_ctrl <= w_gnt1 ? req1_ctrl : req0_ctrl;
            end
            if (r_state == EXEC) begin
                r_resp_data <= alu_out;
                r_resp_zero <= alu_zero;
            end
            if (w_resp_hs) begin
                r_prio     <= ~r_gnt;
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        req0_ready  = w_gnt0;
        req1_ready  = w_gnt1;
        resp0_valid = (r_state == RESP) && !r_gnt;
        resp1_valid = (r_state == RESP) &&  r_gnt;
        resp_data   = r_resp_data;
        resp_zero   = r_resp_zero;
        alu_a       = r_a;
        alu_b       = r_b;
        alu_ctrl    = r_ctrl;
        busy        = (r_state != IDLE);
        op_count    = r_op_count;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_ctrl, req1_ctrl;
    logic             resp0_valid, resp1_valid;
    logic             resp0_ready, resp1_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_zero;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [3:0]       alu_ctrl;
    logic             alu_zero;
    logic             busy;
    logic [15:0]      op_count;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ctrl   (req0_ctrl),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ctrl   (req1_ctrl),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_data   (resp_data),
        .resp_zero   (resp_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .busy        (busy),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: codes above sra return zero.
    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            4'h0: alu_out = alu_a + alu_b;
            4'h1: alu_out = alu_a - alu_b;
            4'h2: alu_out = alu_a & alu_b;
            4'h3: alu_out = alu_a | alu_b;
            4'h4: alu_out = alu_a ^ alu_b;
            4'h5: alu_out = alu_a << alu_b[4:0];
            4'h6: alu_out = alu_a >> alu_b[4:0];
            4'h7: alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            4'h8: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        req0_valid  = 1'b1;
        req1_valid  = 1'b1;
        req0_a      = 32'h1;
        req0_b      = 32'h2;
        req0_ctrl   = 4'h0;
        req1_a      = 32'h3;
        req1_b      = 32'h4;
        req1_ctrl   = 4'h0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;

        // Held in reset with requests pending
        repeat (2) @(negedge clk);
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_resp0_valid", 32'(resp0_valid), 32'd0);
        check("rst_resp1_valid", 32'(resp1_valid), 32'd0);
        check("rst_alu_a",      alu_a,           32'd0);
        check("rst_alu_ctrl",   32'(alu_ctrl),   32'd0);
        check("rst_op_count",   32'(op_count),   32'd0);
        check("rst_resp_data",  resp_data,       32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Single op: 5 - 3
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'h1;
        resp0_ready = 1'b1;
        #1;
        check("t1_req0_ready", 32'(req0_ready), 32'd1);
        check("t1_req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("t1_busy",       32'(busy),     32'd1);
        check("t1_alu_a",      alu_a,         32'd5);
        check("t1_alu_b",      alu_b,         32'd3);
        check("t1_alu_ctrl",   32'(alu_ctrl), 32'd1);
        check("t1_early_resp", 32'(resp0_valid), 32'd0);
        @(negedge clk); #1;
        check("t1_resp0_valid", 32'(resp0_valid), 32'd1);
        check("t1_resp1_valid", 32'(resp1_valid), 32'd0);
        check("t1_resp_data",   resp_data,        32'd2);
        check("t1_resp_zero",   32'(resp_zero),   32'd0);
        @(negedge clk); #1;
        check("t1_idle",     32'(busy),     32'd0);
        check("t1_op_count", 32'(op_count), 32'd1);

        // Contention from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1;   req0_b = 32'd1;   req0_ctrl = 4'h0;
        req1_valid = 1'b1; req1_a = 32'hF0;  req1_b = 32'h0F;  req1_ctrl = 4'h2;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        #1;
        check("t2_op_count_cleared", 32'(op_count), 32'd0);
        check("t2_req0_first",  32'(req0_ready), 32'd1);
        check("t2_req1_wait",   32'(req1_ready), 32'd0);
        @(negedge clk); #1;
        check("t2_ignored_busy", 32'(req1_ready), 32'd0);
        @(negedge clk); #1;
        check("t2_resp0_valid", 32'(resp0_valid), 32'd1);
        check("t2_resp1_quiet", 32'(resp1_valid), 32'd0);
        check("t2_data0",       resp_data,        32'd2);
        @(negedge clk); #1;
        check("t2_req1_granted", 32'(req1_ready), 32'd1);
        check("t2_req0_held",    32'(req0_ready), 32'd0);
        check("t2_count1",       32'(op_count),   32'd1);
        @(negedge clk);
        @(negedge clk); #1;
        check("t2_resp1_valid", 32'(resp1_valid), 32'd1);
        check("t2_data1",       resp_data,        32'd0);
        check("t2_zero1",       32'(resp_zero),   32'd1);
        @(negedge clk); #1;
        check("t2_third_req0",  32'(req0_ready), 32'd1);
        check("t2_third_req1",  32'(req1_ready), 32'd0);
        check("t2_count2",      32'(op_count),   32'd2);
        @(negedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("t2_third_resp", 32'(resp0_valid), 32'd1);
        check("t2_third_data", resp_data,        32'd2);
        @(negedge clk); #1;
        check("t2_count3", 32'(op_count), 32'd3);
        check("t2_idle",   32'(busy),     32'd0);

        // Backpressure on requester 1 (prio now points at 1)
        req1_valid = 1'b1; req1_a = 32'd7;   req1_b = 32'd2;   req1_ctrl = 4'h0;
        req0_valid = 1'b1; req0_a = 32'h11;  req0_b = 32'h22;  req0_ctrl = 4'h3;
        resp1_ready = 1'b0; resp0_ready = 1'b1;
        #1;
        check("t3_req1_prio", 32'(req1_ready), 32'd1);
        check("t3_req0_prio", 32'(req0_ready), 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("t3_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("t3_hold_valid", 32'(resp1_valid), 32'd1);
            check("t3_hold_data",  resp_data,        32'd9);
            check("t3_no_resp0",   32'(resp0_valid), 32'd0);
            check("t3_req0_ignored", 32'(req0_ready), 32'd0);
        end
        @(negedge clk);
        resp1_ready = 1'b1;
        #1;
        check("t3_release_valid", 32'(resp1_valid), 32'd1);
        check("t3_release_data",  resp_data,        32'd9);
        @(negedge clk); #1;
        check("t3_count4",      32'(op_count),    32'd4);
        check("t3_resp1_done",  32'(resp1_valid), 32'd0);
        check("t3_req0_next",   32'(req0_ready),  32'd1);
        req0_valid = 1'b0;
        #1;

        // Reset asserted while in RESP
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 4'h0;
        resp0_ready = 1'b0;
        #1;
        check("t4_req0_ready", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b1;
        @(negedge clk); #1;
        check("t4_in_resp", 32'(resp0_valid), 32'd1);
        check("t4_data",    resp_data,        32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_resp0",    32'(resp0_valid), 32'd0);
        check("t4_rst_busy",     32'(busy),        32'd0);
        check("t4_rst_data",     resp_data,        32'd0);
        check("t4_rst_alu_a",    alu_a,            32'd0);
        check("t4_rst_alu_ctrl", 32'(alu_ctrl),    32'd0);
        check("t4_rst_count",    32'(op_count),    32'd0);
        check("t4_rst_req1",     32'(req1_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_ctrl = 4'h0;
        req1_valid = 1'b1; req1_a = 32'd8; req1_b = 32'd8; req1_ctrl = 4'h0;
        #1;
        check("t4_prio_reset_req0", 32'(req0_ready),  32'd1);
        check("t4_prio_reset_req1", 32'(req1_ready),  32'd0);
        check("t4_no_stale_resp",   32'(resp0_valid), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        check("t4_after_resp", 32'(resp0_valid), 32'd1);
        check("t4_after_data", resp_data,        32'd7);
        @(negedge clk); #1;
        check("t4_after_count", 32'(op_count), 32'd1);

        // Counter wrap plus an undefined ctrl code
        @(negedge clk);
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        req0_valid = 1'b1; req0_a = 32'h1234; req0_b = 32'h5; req0_ctrl = 4'hA;
        #1;
        check("t5_req0_ready", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("t5_alu_ctrl", 32'(alu_ctrl), 32'hA);
        @(negedge clk); #1;
        check("t5_resp_valid", 32'(resp0_valid), 32'd1);
        check("t5_resp_data",  resp_data,        32'd0);
        check("t5_resp_zero",  32'(resp_zero),   32'd1);
        @(negedge clk); #1;
        check("t5_wrap_count", 32'(op_count), 32'd0);
        check("t5_idle",       32'(busy),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
